// File: rtl/idct4_transpose.sv
// Inter-pass stage of the 4x4 inverse transform: rounds/clips row-pass results and
// transposes them through ping-pong 4x4 banks. Optional sticky clip flag: IDCT4_TP_SAT_FLAG_EN.
module idct4_transpose #(
    parameter int WIDTH_IN  = 22,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT     = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_IN-1:0]  y0,
    input  logic signed [WIDTH_IN-1:0]  y1,
    input  logic signed [WIDTH_IN-1:0]  y2,
    input  logic signed [WIDTH_IN-1:0]  y3,
    input  logic                        out_ready,
    output logic                        out_load,
    output logic signed [WIDTH_OUT-1:0] x0,
    output logic signed [WIDTH_OUT-1:0] x1,
    output logic signed [WIDTH_OUT-1:0] x2,
    output logic signed [WIDTH_OUT-1:0] x3,
    output logic                        sat_flag
);

    localparam int WS = WIDTH_IN + 1;
    localparam logic signed [WS-1:0] ROUND_C  = WS'(1) << (SHIFT - 1);
    localparam logic signed [WS-1:0] CLIP_MAX =
        {{(WIDTH_IN - WIDTH_OUT + 2){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [WS-1:0] CLIP_MIN =
        {{(WIDTH_IN - WIDTH_OUT + 2){1'b1}}, {(WIDTH_OUT - 1){1'b0}}};

    logic signed [WIDTH_IN-1:0]  y_in   [4];
    logic signed [WIDTH_OUT-1:0] scaled [4];
`ifdef IDCT4_TP_SAT_FLAG_EN
    logic [3:0] clipped;
`endif

    assign y_in[0] = y0;
    assign y_in[1] = y1;
    assign y_in[2] = y2;
    assign y_in[3] = y3;

    // One extra bit of headroom keeps the rounding add from wrapping at the input extremes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scale
            logic signed [WS-1:0] ext_w;
            logic signed [WS-1:0] sum_w;
            logic signed [WS-1:0] shr_w;
            logic                 hi_w;
            logic                 lo_w;

            assign ext_w = {y_in[gi][WIDTH_IN-1], y_in[gi]};
            assign sum_w = ext_w + ROUND_C;
            assign shr_w = sum_w >>> SHIFT;
            assign hi_w  = shr_w > CLIP_MAX;
            assign lo_w  = shr_w < CLIP_MIN;
            assign scaled[gi] = hi_w ? CLIP_MAX[WIDTH_OUT-1:0] :
                                lo_w ? CLIP_MIN[WIDTH_OUT-1:0] :
                                       shr_w[WIDTH_OUT-1:0];
`ifdef IDCT4_TP_SAT_FLAG_EN
            assign clipped[gi] = hi_w | lo_w;
`endif
        end
    endgenerate

    // Bank storage: [bank][row][column]; contents need no reset.
    logic signed [WIDTH_OUT-1:0] bank_mem [2][4][4];

    logic [1:0]                  full_q,     full_d;
    logic                        wr_bank_q,  wr_bank_d;
    logic                        rd_bank_q,  rd_bank_d;
    logic [1:0]                  row_q,      row_d;
    logic [1:0]                  col_q,      col_d;
    logic                        out_load_q, out_load_d;
    logic signed [WIDTH_OUT-1:0] x_q [4];
    logic signed [WIDTH_OUT-1:0] x_d [4];

    logic wr_fire;
    logic out_adv;
    logic rd_fire;

    assign in_ready = ~full_q[wr_bank_q];
    assign wr_fire  = in_valid & in_ready;
    assign out_adv  = ~out_load_q | out_ready;
    assign rd_fire  = out_adv & full_q[rd_bank_q];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
                bank_mem[wr_bank_q][row_q][k] <= scaled[k];
            end
        end
    end

    // Write and read sides always touch different banks, so both full updates can apply together.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        row_d      = row_q;
        col_d      = col_q;
        out_load_d = out_load_q;
        x_d        = x_q;

        if (wr_fire) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                row_d             = 2'd0;
            end
        end

        if (out_adv) begin
            if (rd_fire) begin
                out_load_d = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    x_d[k] = bank_mem[rd_bank_q][k][col_q];
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    col_d             = 2'd0;
                end
            end else begin
                out_load_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            row_q      <= 2'd0;
            col_q      <= 2'd0;
            out_load_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            out_load_q <= out_load_d;
            x_q        <= x_d;
        end
    end

    assign out_load = out_load_q;
    assign x0       = x_q[0];
    assign x1       = x_q[1];
    assign x2       = x_q[2];
    assign x3       = x_q[3];

`ifdef IDCT4_TP_SAT_FLAG_EN
    logic sat_flag_q, sat_flag_d;

    always_comb begin
        sat_flag_d = sat_flag_q | (wr_fire & (|clipped));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
        end else begin
            sat_flag_q <= sat_flag_d;
        end
    end

    assign sat_flag = sat_flag_q;
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_idct4_transpose.sv
// Scoreboard bench for idct4_transpose: SHIFT=7 instance plus a SHIFT=5 instance for clipping.
module tb_idct4_transpose;

`ifdef IDCT4_TP_SAT_FLAG_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic signed [21:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0;

    logic in_ready, out_load, sat7;
    logic signed [15:0] x0, x1, x2, x3;
    logic in_ready5, out_load5, sat5;
    logic signed [15:0] z0, z1, z2, z3;

    always #5 clk = ~clk;

    idct4_transpose #(.WIDTH_IN(22), .WIDTH_OUT(16), .SHIFT(7)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_ready(out_ready), .out_load(out_load),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .sat_flag(sat7)
    );

    idct4_transpose #(.WIDTH_IN(22), .WIDTH_OUT(16), .SHIFT(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_ready(out_ready), .out_load(out_load5),
        .x0(z0), .x1(z1), .x2(z2), .x3(z3), .sat_flag(sat5)
    );

    typedef struct {
        logic [63:0] e7;
        logic [63:0] e5;
        bit          c5;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int rows_acc = 0;
    int n_pops = 0;
    int streak = 0;
    int max_streak = 0;
    bit expect_ready = 1'b0;

    logic signed [21:0] by [4][4];
    logic signed [15:0] e7 [4][4];
    logic signed [15:0] e5 [4][4];
    bit c5;

    task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, expv);
        end
    endtask

    // Monitor: compares every presented column against the scoreboard head, also while stalled.
    always @(negedge clk) begin
        if (rst) begin
            streak = 0;
        end else if (out_load) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_col got=%h exp=none", {x0, x1, x2, x3});
            end else begin
                if ({x0, x1, x2, x3} !== q[0].e7) begin
                    n_fail++;
                    $display("FAIL col_s7 got=%h exp=%h", {x0, x1, x2, x3}, q[0].e7);
                end
                if (q[0].c5) begin
                    n_cmp++;
                    if ({z0, z1, z2, z3} !== q[0].e5) begin
                        n_fail++;
                        $display("FAIL col_s5 got=%h exp=%h", {z0, z1, z2, z3}, q[0].e5);
                    end
                end
                $display("col %0d: s7=%h ready=%0b", n_pops, {x0, x1, x2, x3}, out_ready);
                if (out_ready) begin
                    q.delete(0);
                    n_pops++;
                end
            end
        end else begin
            streak = 0;
        end
    end

    task automatic send_row(input logic signed [21:0] a, b, c, d);
        bit ok;
        ok = 1'b0;
        y0 = a; y1 = b; y2 = c; y3 = d;
        in_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (expect_ready) chk("stream_in_ready", in_ready, 1);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (ok) rows_acc++;
        else begin
            n_cmp++;
            n_fail++;
            $display("FAIL row_timeout got=stalled exp=accepted");
        end
    endtask

    task automatic send_block();
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            send_row(by[r][0], by[r][1], by[r][2], by[r][3]);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            e.e7 = {e7[0][c], e7[1][c], e7[2][c], e7[3][c]};
            e.e5 = {e5[0][c], e5[1][c], e5[2][c], e5[3][c]};
            e.c5 = c5;
            q.push_back(e);
        end
    endtask

    // Row r element k carries (base+4r+k)*128: 7-bit shift yields the index, 5-bit shift four times it.
    task automatic set_simple(input int base);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                by[r][k] = 22'((base + 4 * r + k) * 128);
                e7[r][k] = 16'(base + 4 * r + k);
                e5[r][k] = 16'((base + 4 * r + k) * 4);
            end
        end
        c5 = 1'b1;
    endtask

    task automatic set_zero();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                by[r][k] = '0;
                e7[r][k] = '0;
                e5[r][k] = '0;
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_load) break;
        end
        chk(nm, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops_before;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_load", out_load, 0);
        chk("rst_x0", x0, 0);
        chk("rst_x3", x3, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sat7", sat7, 0);
        chk("rst_sat5", sat5, 0);
        @(posedge clk);
        #1;

        // Transpose with latency check
        set_simple(0);
        send_block();
        @(negedge clk);
        chk("lat_early", out_load, 0);
        @(negedge clk);
        chk("lat_first", out_load, 1);
        wait_drain("transpose_drain");

        // Rounding: 63,64,-64,-65,191 -> 0,1,0,-1,1
        set_zero();
        by[0][0] = 22'(63);  by[0][1] = 22'(64);  by[0][2] = 22'(-64); by[0][3] = 22'(-65);
        by[1][0] = 22'(191);
        e7[0][0] = 16'(0);   e7[0][1] = 16'(1);   e7[0][2] = 16'(0);   e7[0][3] = 16'(-1);
        e7[1][0] = 16'(1);
        c5 = 1'b0;
        send_block();
        wait_drain("round_drain");

        // Streaming: 5 blocks back to back
        max_streak = 0;
        expect_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            set_simple(16 * b);
            send_block();
        end
        expect_ready = 1'b0;
        wait_drain("stream_drain");
        chk("stream_streak", max_streak, 20);

        // Backpressure: 3 blocks offered with out_ready low
        rows_acc = 0;
        pops_before = n_pops;
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    set_simple(200 + 16 * b);
                    send_block();
                end
            end
            begin
                for (int t = 0; t < 200 && rows_acc < 8; t++) @(negedge clk);
                chk("bp_rows_before_stall", rows_acc, 8);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_load_held", out_load, 1);
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        chk("bp_col_count", n_pops - pops_before, 12);

        // Clip at SHIFT=5; the same rows stay in range at SHIFT=7
        set_zero();
        for (int r = 0; r < 4; r++) begin
            by[r][0] = 22'(2097151);
            by[r][1] = 22'(-2097152);
            e7[r][0] = 16'(16384);
            e7[r][1] = 16'(-16384);
            e5[r][0] = 16'(32767);
            e5[r][1] = 16'(-32768);
        end
        c5 = 1'b1;
        send_block();
        wait_drain("clip_drain");
        chk("clip_sat5", sat5, SAT_ON);
        chk("clip_sat7", sat7, 0);

        set_simple(100);
        send_block();
        wait_drain("noclip_drain");
        chk("sticky_sat5", sat5, SAT_ON);

        // Reset after two rows of a block, then a fresh block
        set_simple(40);
        send_row(by[0][0], by[0][1], by[0][2], by[0][3]);
        send_row(by[1][0], by[1][1], by[1][2], by[1][3]);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_load", out_load, 0);
        chk("mid_rst_x0", x0, 0);
        chk("mid_rst_x3", x3, 0);
        chk("mid_rst_sat5", sat5, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        pops_before = n_pops;
        set_simple(60);
        send_block();
        wait_drain("fresh_drain");
        chk("fresh_col_count", n_pops - pops_before, 4);

        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
